// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths and the execute-bundle payload for operand_fetch_stage.
// Widths are package constants so the bundle struct and every user stay consistent.
package operand_fetch_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned NREGS  = 1 << ADDR_W;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic              wr;
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } ex_bundle_t;

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-write scoreboard: one bit per register, set wins over clear,
// three combinational lookups (src1, src2, dest).
module operand_fetch_stage_scoreboard
   import operand_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] look1_addr,
   input  logic [ADDR_W-1:0] look2_addr,
   input  logic [ADDR_W-1:0] look3_addr,
   output logic              pend1_c,
   output logic              pend2_c,
   output logic              pend3_c,
   output logic [NREGS-1:0]  pending
);

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;

   // Clear applied first so a same-cycle set of the same register survives
   always_comb begin
      pending_d = pending_q;
      if (clr_en) pending_d[clr_addr] = 1'b0;
      if (set_en) pending_d[set_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending_q <= '0;
      else        pending_q <= pending_d;
   end

   assign pend1_c = pending_q[look1_addr];
   assign pend2_c = pending_q[look2_addr];
   assign pend3_c = pending_q[look3_addr];
   assign pending = pending_q;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads the register bank, blocks RAW/WAW hazards via a
// scoreboard and holds one instruction for execute. Optional macro: WB_BYPASS_EN.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [OP_W-1:0]   issue_op,
   input  logic              issue_wr,
   input  logic [ADDR_W-1:0] issue_dest,
   input  logic [ADDR_W-1:0] issue_src1,
   input  logic [ADDR_W-1:0] issue_src2,
   output logic [ADDR_W-1:0] rf_srcadd1,
   output logic [ADDR_W-1:0] rf_srcadd2,
   input  logic [DATA_W-1:0] rf_src1,
   input  logic [DATA_W-1:0] rf_src2,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [OP_W-1:0]   ex_op,
   output logic              ex_wr,
   output logic [ADDR_W-1:0] ex_dest,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_data,
   output logic [NREGS-1:0]  sb_pending
);

   ex_bundle_t        ex_q, ex_d;
   logic              ex_valid_q, ex_valid_d;
   logic              pend1_c, pend2_c, pend3_c;
   logic              raw1_c, raw2_c;
   logic              slot_free_c, hazard_c, ready_c, accept_c;
   logic [DATA_W-1:0] op_a_c, op_b_c;

   assign rf_srcadd1 = issue_src1;
   assign rf_srcadd2 = issue_src2;

   operand_fetch_stage_scoreboard u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en     (accept_c & issue_wr),
      .set_addr   (issue_dest),
      .clr_en     (wb_valid),
      .clr_addr   (wb_dest),
      .look1_addr (issue_src1),
      .look2_addr (issue_src2),
      .look3_addr (issue_dest),
      .pend1_c    (pend1_c),
      .pend2_c    (pend2_c),
      .pend3_c    (pend3_c),
      .pending    (sb_pending)
   );

`ifdef WB_BYPASS_EN
   // A source being written back this cycle is taken from the writeback bus
   logic byp1_c, byp2_c;
   assign byp1_c = wb_valid & (wb_dest == issue_src1);
   assign byp2_c = wb_valid & (wb_dest == issue_src2);
   assign raw1_c = pend1_c & ~byp1_c;
   assign raw2_c = pend2_c & ~byp2_c;
   assign op_a_c = byp1_c ? wb_data : rf_src1;
   assign op_b_c = byp2_c ? wb_data : rf_src2;
`else
   logic unused_wb_data_c;
   assign raw1_c = pend1_c;
   assign raw2_c = pend2_c;
   assign op_a_c = rf_src1;
   assign op_b_c = rf_src2;
   assign unused_wb_data_c = ^wb_data;
`endif

   // WAW check deliberately ignores any same-cycle writeback
   always_comb begin
      slot_free_c = ~ex_valid_q | ex_ready;
      hazard_c    = raw1_c | raw2_c | (issue_wr & pend3_c);
      ready_c     = slot_free_c & ~hazard_c;
      accept_c    = issue_valid & ready_c;
   end

   assign issue_ready = ready_c;

   always_comb begin
      ex_d       = ex_q;
      ex_valid_d = ex_valid_q;
      if (accept_c) begin
         ex_d.op    = issue_op;
         ex_d.wr    = issue_wr;
         ex_d.dest  = issue_dest;
         ex_d.a     = op_a_c;
         ex_d.b     = op_b_c;
         ex_valid_d = 1'b1;
      end else if (ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q       <= '0;
         ex_valid_q <= 1'b0;
      end else begin
         ex_q       <= ex_d;
         ex_valid_q <= ex_valid_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_op    = ex_q.op;
   assign ex_wr    = ex_q.wr;
   assign ex_dest  = ex_q.dest;
   assign ex_a     = ex_q.a;
   assign ex_b     = ex_q.b;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural register bank.
module tb_operand_fetch_stage;
   import operand_fetch_stage_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              issue_valid, issue_ready, issue_wr;
   logic [OP_W-1:0]   issue_op;
   logic [ADDR_W-1:0] issue_dest, issue_src1, issue_src2;
   logic [ADDR_W-1:0] rf_srcadd1, rf_srcadd2;
   logic [DATA_W-1:0] rf_src1, rf_src2;
   logic              ex_valid, ex_ready, ex_wr;
   logic [OP_W-1:0]   ex_op;
   logic [ADDR_W-1:0] ex_dest;
   logic [DATA_W-1:0] ex_a, ex_b;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_dest;
   logic [DATA_W-1:0] wb_data;
   logic [NREGS-1:0]  sb_pending;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [DATA_W-1:0] rf [NREGS];

   always #5 clk = ~clk;

   assign rf_src1 = rf[rf_srcadd1];
   assign rf_src2 = rf[rf_srcadd2];

   // Bank commits writebacks on the edge
   always @(posedge clk) if (rst_n && wb_valid) rf[wb_dest] <= wb_data;

   operand_fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_wr(issue_wr), .issue_dest(issue_dest), .issue_src1(issue_src1),
      .issue_src2(issue_src2), .rf_srcadd1(rf_srcadd1), .rf_srcadd2(rf_srcadd2),
      .rf_src1(rf_src1), .rf_src2(rf_src2), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_op(ex_op), .ex_wr(ex_wr), .ex_dest(ex_dest), .ex_a(ex_a), .ex_b(ex_b),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .sb_pending(sb_pending)
   );

   typedef struct {
      string       name;
      logic        iv;
      logic        wr;
      logic [5:0]  op;
      logic [3:0]  dest;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        exr;
      logic        wbv;
      logic [3:0]  wbd;
      logic [31:0] wbdata;
      logic        rdy;
      logic        exv;
      logic [5:0]  xop;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  xdest;
      logic [15:0] sb;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic wr, input logic [5:0] op,
                        input logic [3:0] dest, input logic [3:0] s1, input logic [3:0] s2,
                        input logic exr, input logic wbv, input logic [3:0] wbd,
                        input logic [31:0] wbdata);
      issue_valid = iv; issue_wr = wr; issue_op = op; issue_dest = dest;
      issue_src1 = s1; issue_src2 = s2; ex_ready = exr;
      wb_valid = wbv; wb_dest = wbd; wb_data = wbdata;
   endtask

   task automatic check_ex(input string tag, input logic exv, input logic [5:0] xop,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] xdest, input logic [15:0] sb);
      chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(exv));
      chk({tag, ".ex_op"}, 32'(ex_op), 32'(xop));
      chk({tag, ".ex_a"}, ex_a, a);
      chk({tag, ".ex_b"}, ex_b, b);
      chk({tag, ".ex_dest"}, 32'(ex_dest), 32'(xdest));
      chk({tag, ".sb_pending"}, 32'(sb_pending), 32'(sb));
   endtask

   // One cycle: drive at negedge, check ready before the edge, outputs after it
   task automatic cycle(input string tag, input logic rdy_exp);
      #1 chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(rdy_exp));
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] = 32'h100 + 32'(i);
      rf[3] = 32'h11;
      rf[4] = 32'h22;

      //           name        iv wr op  dst s1 s2 exr wbv wbd wbdata     rdy exv xop a          b          xd  sb
      vecs[0] = '{"waw_set",   1, 1, 2,  7,  1, 2, 1,  0,  0,  32'h0,     1,  1,  2,  32'h101,   32'h102,   7,  16'h00A0};
      vecs[1] = '{"waw_stall", 1, 1, 9,  7,  1, 2, 1,  0,  0,  32'h0,     0,  0,  2,  32'h101,   32'h102,   7,  16'h00A0};
      vecs[2] = '{"waw_nowr",  1, 0, 3,  7,  1, 2, 1,  0,  0,  32'h0,     1,  1,  3,  32'h101,   32'h102,   7,  16'h00A0};
      vecs[3] = '{"wb_clr7",   0, 0, 0,  0,  0, 0, 1,  1,  7,  32'h77,    1,  0,  3,  32'h101,   32'h102,   7,  16'h0020};
      vecs[4] = '{"wb_nopend", 0, 0, 0,  0,  0, 0, 1,  1,  2,  32'h222,   1,  0,  3,  32'h101,   32'h102,   7,  16'h0020};
      vecs[5] = '{"src_eq_dst",1, 1, 6,  2,  2, 7, 1,  0,  0,  32'h0,     1,  1,  6,  32'h222,   32'h77,    2,  16'h0024};
      vecs[6] = '{"src_dup",   1, 0, 8,  0,  2, 2, 1,  0,  0,  32'h0,     0,  0,  6,  32'h222,   32'h77,    2,  16'h0024};

      // Reset held with an instruction offered
      rst_n = 1'b0;
      drive(1, 1, 6'd1, 4'd5, 4'd3, 4'd4, 1, 0, 0, 32'h0);
      repeat (2) @(posedge clk);
      #1 check_ex("reset", 1'b0, 6'd0, 32'h0, 32'h0, 4'd0, 16'h0000);

      // Release: first accept on the next edge
      @(negedge clk);
      rst_n = 1'b1;
      cycle("basic", 1'b1);
      check_ex("basic", 1'b1, 6'd1, 32'h11, 32'h22, 4'd5, 16'h0020);
      chk("basic.ex_wr", 32'(ex_wr), 32'd1);

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(vecs[i].iv, vecs[i].wr, vecs[i].op, vecs[i].dest, vecs[i].s1, vecs[i].s2,
               vecs[i].exr, vecs[i].wbv, vecs[i].wbd, vecs[i].wbdata);
         cycle(vecs[i].name, vecs[i].rdy);
         check_ex(vecs[i].name, vecs[i].exv, vecs[i].xop, vecs[i].a, vecs[i].b,
                  vecs[i].xdest, vecs[i].sb);
      end

      // RAW on r5: stalls until its writeback
      @(negedge clk);
      drive(1, 0, 6'd4, 4'd0, 4'd5, 4'd4, 1, 0, 0, 32'h0);
      cycle("raw_wait", 1'b0);
      check_ex("raw_wait", 1'b0, 6'd6, 32'h222, 32'h77, 4'd2, 16'h0024);
      @(negedge clk);
      drive(1, 0, 6'd4, 4'd0, 4'd5, 4'd4, 1, 1, 4'd5, 32'hABCD);
`ifdef WB_BYPASS_EN
      cycle("raw_byp", 1'b1);
      check_ex("raw_byp", 1'b1, 6'd4, 32'hABCD, 32'h22, 4'd0, 16'h0004);
`else
      cycle("raw_wbcyc", 1'b0);
      check_ex("raw_wbcyc", 1'b0, 6'd6, 32'h222, 32'h77, 4'd2, 16'h0004);
      @(negedge clk);
      drive(1, 0, 6'd4, 4'd0, 4'd5, 4'd4, 1, 0, 0, 32'h0);
      cycle("raw_after", 1'b1);
      check_ex("raw_after", 1'b1, 6'd4, 32'hABCD, 32'h22, 4'd0, 16'h0004);
`endif
      @(negedge clk);
      drive(0, 0, 6'd0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 32'h0);
      cycle("drain", 1'b1);
      chk("drain.ex_valid", 32'(ex_valid), 32'd0);

      // Backpressure: A loaded, B offered while execute stalls
      @(negedge clk);
      drive(1, 1, 6'd5, 4'd8, 4'd3, 4'd4, 0, 0, 0, 32'h0);
      cycle("bp_load", 1'b1);
      check_ex("bp_load", 1'b1, 6'd5, 32'h11, 32'h22, 4'd8, 16'h0104);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive(1, 1, 6'd6, 4'd10, 4'd1, 4'd3, 0, 0, 0, 32'h0);
         cycle("bp_hold", 1'b0);
         check_ex("bp_hold", 1'b1, 6'd5, 32'h11, 32'h22, 4'd8, 16'h0104);
      end
      @(negedge clk);
      drive(1, 1, 6'd6, 4'd10, 4'd1, 4'd3, 1, 0, 0, 32'h0);
      cycle("bp_swap", 1'b1);
      check_ex("bp_swap", 1'b1, 6'd6, 32'h101, 32'h11, 4'd10, 16'h0504);

      // Set and clear of r9 in the same cycle: set wins
      @(negedge clk);
      drive(1, 1, 6'd7, 4'd9, 4'd1, 4'd3, 1, 1, 4'd9, 32'h999);
      cycle("collide", 1'b1);
      check_ex("collide", 1'b1, 6'd7, 32'h101, 32'h11, 4'd9, 16'h0704);
      chk("collide.bit9", 32'(sb_pending[9]), 32'd1);

      // Asynchronous reset mid-cycle discards instruction and scoreboard
      @(negedge clk);
      drive(0, 0, 6'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 32'h0);
      #2 rst_n = 1'b0;
      #1 check_ex("rst_mid", 1'b0, 6'd0, 32'h0, 32'h0, 4'd0, 16'h0000);
      chk("rst_mid.ex_wr", 32'(ex_wr), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
